ad56x8_dac_ctrl: RTL and testbench

- Parametrised SPI write controller for the AD5608/AD5618/AD5628 octal DAC family (8/10/12-bit).
- Sends the internal-reference setup frame after reset, then accepts per-channel write commands over a ready/valid handshake.
- Serialises each command as a 32-bit frame on sclk/cs/mosi.
- Sits between the sample-generation logic and the DAC pins.

---
 rtl/ad56x8_dac_ctrl.sv | 149 ++++++++++++++
 tb/tb_ad56x8_dac_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad56x8_dac_ctrl.sv
// rtl/ad56x8_dac_ctrl.sv - SPI write controller for the AD5608/AD5618/AD5628 octal DAC family
module ad56x8_dac_ctrl #(
    parameter int          DATA_W    = 12,
    parameter int          CLK_DIV   = 50,
    parameter int          GAP_CYC   = 4,
    parameter logic [31:0] INIT_WORD = 32'h08000001,
    parameter bit          AUTO_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              st_wrt,
    input  logic              req,
    output logic              ready,
    input  logic [3:0]        cmd,
    input  logic [3:0]        ch,
    input  logic [DATA_W-1:0] data_in,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic              done,
    output logic              err,
    output logic              init_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int PAD_W = 20 - DATA_W;

    typedef enum logic [2:0] {
        S_RST,
        S_INIT,
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t            state;
    // Bits still to be shifted out after the one currently on mosi.
    logic [30:0]       shreg;
    logic [5:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              is_init;
    logic              ch_ok;
    logic [31:0]       cmd_frame;

    // Channels 0..7 and the broadcast address 15 are the only ones the DAC decodes.
    assign ch_ok     = (ch[3] == 1'b0) || (ch == 4'hF);
    assign cmd_frame = {4'h0, cmd, ch, data_in, {PAD_W{1'b0}}};

    // Control FSM: init frame, command acceptance, bit serialisation and inter-frame gap.
    always_ff @(posedge clk or negedge st_wrt) begin
        if (!st_wrt) begin
            state     <= S_RST;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            is_init   <= 1'b0;
            ready     <= 1'b0;
            sclk      <= 1'b1;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_RST: begin
                    if (AUTO_INIT) begin
                        state <= S_INIT;
                    end else begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_INIT: begin
                    shreg   <= INIT_WORD[30:0];
                    mosi    <= INIT_WORD[31];
                    cs      <= 1'b0;
                    sclk    <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    is_init <= 1'b1;
                    state   <= S_SEND;
                end
                S_IDLE: begin
                    if (req && ready) begin
                        ready <= 1'b0;
                        if (ch_ok) begin
                            shreg   <= cmd_frame[30:0];
                            mosi    <= cmd_frame[31];
                            cs      <= 1'b0;
                            sclk    <= 1'b1;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                            is_init <= 1'b0;
                            state   <= S_SEND;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling edge: the DAC samples mosi here.
                            sclk <= 1'b0;
                        end else begin
                            sclk <= 1'b1;
                            if (bit_cnt == 6'd31) begin
                                // 32 bits sampled: close the frame on this rising edge.
                                cs      <= 1'b1;
                                mosi    <= 1'b0;
                                gap_cnt <= '0;
                                state   <= S_GAP;
                                if (is_init) begin
                                    init_done <= 1'b1;
                                end else begin
                                    done <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                mosi    <= shreg[30];
                                shreg   <= {shreg[29:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ad56x8_dac_ctrl.sv
// tb/tb_ad56x8_dac_ctrl.sv - self-checking bench for ad56x8_dac_ctrl (12-bit auto-init and 8-bit no-init instances)
module tb_ad56x8_dac_ctrl;

    localparam int A_DW  = 12;
    localparam int A_DIV = 4;
    localparam int A_GAP = 4;
    localparam int B_DW  = 8;
    localparam int B_DIV = 2;
    localparam int B_GAP = 1;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, req_a, req_b;
    logic [3:0]  cmd_d, ch_d;
    logic [11:0] data_d;
    logic        ready_a, sclk_a, cs_a, mosi_a, done_a, err_a, init_a;
    logic        ready_b, sclk_b, cs_b, mosi_b, done_b, err_b, init_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Free-running system clock.
    always #5 clk = ~clk;

    ad56x8_dac_ctrl #(.DATA_W(A_DW), .CLK_DIV(A_DIV), .GAP_CYC(A_GAP),
                      .INIT_WORD(32'h08000001), .AUTO_INIT(1'b1)) dut_a (
        .clk(clk), .st_wrt(rst_a), .req(req_a), .ready(ready_a),
        .cmd(cmd_d), .ch(ch_d), .data_in(data_d),
        .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a),
        .done(done_a), .err(err_a), .init_done(init_a)
    );

    ad56x8_dac_ctrl #(.DATA_W(B_DW), .CLK_DIV(B_DIV), .GAP_CYC(B_GAP),
                      .INIT_WORD(32'h08000001), .AUTO_INIT(1'b0)) dut_b (
        .clk(clk), .st_wrt(rst_b), .req(req_b), .ready(ready_b),
        .cmd(cmd_d), .ch(ch_d), .data_in(data_d[7:0]),
        .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b),
        .done(done_b), .err(err_b), .init_done(init_b)
    );

    logic [1:0] cs_v, sclk_v, mosi_v, done_v, err_v, init_v, ready_v;
    assign cs_v    = {cs_b, cs_a};
    assign sclk_v  = {sclk_b, sclk_a};
    assign mosi_v  = {mosi_b, mosi_a};
    assign done_v  = {done_b, done_a};
    assign err_v   = {err_b, err_a};
    assign init_v  = {init_b, init_a};
    assign ready_v = {ready_b, ready_a};

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          len;
        logic        done_rise;
        logic        init_rise;
        logic        init_before;
        int          fall_cyc;
        int          rise_cyc;
    } frame_t;

    frame_t      fr [2][64];
    int          wr [2];
    int          rd [2];
    logic [31:0] sh [2];
    int          nb [2];
    int          ln [2];
    int          fcyc [2];
    int          done_cnt [2];
    int          err_cnt [2];
    int          pulse_long [2];
    int          idle_tog [2];
    int          fall_cnt [2];
    int          ready_rise [2];
    logic [1:0]  pcs = 2'b11, psclk = 2'b11, pdone = 2'b00, perr = 2'b00;
    logic [1:0]  pinit = 2'b00, pready = 2'b00;

    // Cycle counter used to timestamp bus events.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: reconstructs each frame as the DAC would see it (mosi sampled on sclk falls).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pcs[i] && !cs_v[i]) begin
                sh[i] = 32'h0; nb[i] = 0; ln[i] = 0; fcyc[i] = cyc; fall_cnt[i]++;
            end
            if (!cs_v[i]) begin
                ln[i]++;
                if (psclk[i] && !sclk_v[i]) begin
                    sh[i] = {sh[i][30:0], mosi_v[i]};
                    nb[i]++;
                end
            end
            if (!pcs[i] && cs_v[i] && wr[i] < 64) begin
                fr[i][wr[i]] = '{word: sh[i], nbits: nb[i], len: ln[i], done_rise: done_v[i],
                                 init_rise: init_v[i], init_before: pinit[i],
                                 fall_cyc: fcyc[i], rise_cyc: cyc};
                wr[i]++;
            end
            if (pcs[i] && cs_v[i] && (psclk[i] != sclk_v[i])) idle_tog[i]++;
            if (done_v[i] && !pdone[i]) done_cnt[i]++;
            if (err_v[i] && !perr[i]) err_cnt[i]++;
            if ((done_v[i] && pdone[i]) || (err_v[i] && perr[i])) pulse_long[i]++;
            if (ready_v[i] && !pready[i]) ready_rise[i] = cyc;
        end
        pcs    = cs_v;
        psclk  = sclk_v;
        pdone  = done_v;
        perr   = err_v;
        pinit  = init_v;
        pready = ready_v;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: frame layout from the command fields using plain arithmetic.
    function automatic logic [31:0] exp_frame(input int dw, input logic [3:0] c,
                                              input logic [3:0] h, input logic [11:0] d);
        logic [31:0] mask;
        mask = (32'd1 << dw) - 32'd1;
        return (32'(c) << 24) | (32'(h) << 20) | ((32'(d) & mask) << (20 - dw));
    endfunction

    function automatic bit legal(input logic [3:0] h);
        return (h < 4'd8) || (h == 4'd15);
    endfunction

    function automatic logic rdy(input int inst);
        return (inst == 0) ? ready_a : ready_b;
    endfunction

    task automatic get_frame(input int inst, input int budget, input string tag, output frame_t f);
        int t;
        t = 0;
        while (wr[inst] == rd[inst] && t < budget) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_arrived"}, 64'(wr[inst] != rd[inst]), 64'd1);
        if (wr[inst] != rd[inst]) begin
            f = fr[inst][rd[inst]];
            rd[inst]++;
        end else begin
            f = '{word: 32'h0, nbits: -1, len: -1, done_rise: 1'b0, init_rise: 1'b0,
                  init_before: 1'b0, fall_cyc: 0, rise_cyc: 0};
        end
    endtask

    task automatic issue(input int inst, input logic [3:0] c, input logic [3:0] h, input logic [11:0] d);
        int t;
        t = 0;
        @(negedge clk); #1;
        while (rdy(inst) !== 1'b1 && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        chk("ready_wait", 64'(rdy(inst)), 64'd1);
        cmd_d  = c;
        ch_d   = h;
        data_d = d;
        if (inst == 0) req_a = 1'b1; else req_b = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic check_cmd(input int inst, input string tag, input logic [3:0] c,
                             input logic [3:0] h, input logic [11:0] d);
        frame_t f;
        int dw, div, d0, e0;
        dw  = (inst == 0) ? A_DW : B_DW;
        div = (inst == 0) ? A_DIV : B_DIV;
        d0  = done_cnt[inst];
        e0  = err_cnt[inst];
        issue(inst, c, h, d);
        if (legal(h)) begin
            get_frame(inst, 64 * div + 50, tag, f);
            chk({tag, "_word"}, 64'(f.word), 64'(exp_frame(dw, c, h, d)));
            chk({tag, "_nbits"}, 64'(f.nbits), 64'd32);
            chk({tag, "_len"}, 64'(f.len), 64'(64 * div));
            chk({tag, "_done_at_cs_rise"}, 64'(f.done_rise), 64'd1);
            chk({tag, "_done_count"}, 64'(done_cnt[inst] - d0), 64'd1);
        end else begin
            repeat (4) @(negedge clk);
            #1;
            chk({tag, "_err_count"}, 64'(err_cnt[inst] - e0), 64'd1);
            chk({tag, "_no_frame"}, 64'(wr[inst] - rd[inst]), 64'd0);
            chk({tag, "_cs_high"}, 64'(cs_v[inst]), 64'd1);
        end
        chk({tag, "_pulse_width"}, 64'(pulse_long[inst]), 64'd0);
    endtask

    // Watchdog: guarantees termination even if a handshake never completes.
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence with a randomized middle section.
    initial begin
        frame_t f, f1, f2, f3;
        int s, t;
        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        cmd_d = 4'h0; ch_d = 4'h0; data_d = 12'h0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_sclk", 64'(sclk_a), 64'd1);
        chk("rst_cs", 64'(cs_a), 64'd1);
        chk("rst_mosi", 64'(mosi_a), 64'd0);
        chk("rst_ready", 64'(ready_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_init_done", 64'(init_a), 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_b", 64'({cs_b, sclk_b, mosi_b, ready_b, init_b}), 64'b11000);
        rst_a = 1'b1; rst_b = 1'b1;

        // Init frame on the auto-init instance.
        get_frame(0, 400, "init", f);
        chk("init_word", 64'(f.word), 64'h08000001);
        chk("init_nbits", 64'(f.nbits), 64'd32);
        chk("init_len", 64'(f.len), 64'(64 * A_DIV));
        chk("init_no_done", 64'(f.done_rise), 64'd0);
        chk("init_done_with_cs", 64'({f.init_before, f.init_rise}), 64'b01);
        chk("init_done_count", 64'(done_cnt[0]), 64'd0);
        repeat (A_GAP + 4) @(negedge clk);
        #1;
        chk("init_ready_delay", 64'(ready_rise[0] - f.rise_cyc), 64'(A_GAP));

        // No-init instance goes straight to idle.
        chk("b_init_done", 64'(init_b), 64'd1);
        chk("b_ready", 64'(ready_b), 64'd1);
        chk("b_no_frame", 64'(wr[1]), 64'd0);

        check_cmd(0, "a_abc", 4'h3, 4'h3, 12'hABC);
        check_cmd(1, "b_ch7", 4'h3, 4'h7, 12'h05A);
        check_cmd(1, "b_ch15", 4'h3, 4'hF, 12'h0FF);
        check_cmd(0, "a_ch9", 4'h3, 4'h9, 12'h111);
        check_cmd(0, "a_after_err", 4'h3, 4'h4, 12'h222);
        check_cmd(1, "b_ch12", 4'h2, 4'hC, 12'h033);

        for (int k = 0; k < 10; k++) begin
            check_cmd(k % 2, $sformatf("rand%0d", k), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 12'($urandom));
        end

        // A second request during SEND is dropped, not queued.
        issue(0, 4'h3, 4'h2, 12'h123);
        cmd_d = 4'h3; ch_d = 4'h6; data_d = 12'h456; req_a = 1'b1;
        repeat (100) @(negedge clk);
        req_a = 1'b0;
        get_frame(0, 300, "ign", f);
        chk("ign_word", 64'(f.word), 64'(exp_frame(A_DW, 4'h3, 4'h2, 12'h123)));
        repeat (400) @(negedge clk);
        #1;
        chk("ign_single_frame", 64'(wr[0] - rd[0]), 64'd0);

        // req held high: back-to-back frames at full throughput.
        @(negedge clk); #1;
        s = fall_cnt[0];
        cmd_d = 4'h3; ch_d = 4'h5; data_d = 12'h777; req_a = 1'b1;
        t = 0;
        while (fall_cnt[0] < s + 3 && t < 1200) begin
            @(negedge clk); #1; t++;
        end
        req_a = 1'b0;
        get_frame(0, 300, "b2b1", f1);
        get_frame(0, 300, "b2b2", f2);
        get_frame(0, 300, "b2b3", f3);
        chk("b2b_word1", 64'(f1.word), 64'h03577700);
        chk("b2b_word3", 64'(f3.word), 64'h03577700);
        chk("b2b_period12", 64'(f2.fall_cyc - f1.fall_cyc), 64'(1 + 64 * A_DIV + A_GAP));
        chk("b2b_period23", 64'(f3.fall_cyc - f2.fall_cyc), 64'(1 + 64 * A_DIV + A_GAP));
        chk("b2b_gap_min", 64'((f2.fall_cyc - f1.rise_cyc) >= A_GAP), 64'd1);
        repeat (400) @(negedge clk);
        #1;
        chk("b2b_exactly3", 64'(wr[0] - rd[0]), 64'd0);
        chk("a_idle_sclk_quiet", 64'(idle_tog[0]), 64'd0);
        chk("b_idle_sclk_quiet", 64'(idle_tog[1]), 64'd0);

        // Reset in the middle of bit 17 aborts the frame immediately.
        issue(0, 4'h3, 4'h1, 12'hFED);
        t = 0;
        while (!(nb[0] == 17 && cs_a == 1'b0) && t < 300) begin
            @(negedge clk); #1; t++;
        end
        chk("mid_reached_bit17", 64'(nb[0]), 64'd17);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({cs_a, sclk_a, mosi_a, ready_a, init_a, done_a}), 64'b110000);
        get_frame(0, 50, "mid_partial", f);
        chk("mid_partial_bits", 64'(f.nbits), 64'd17);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        get_frame(0, 400, "reinit", f);
        chk("reinit_word", 64'(f.word), 64'h08000001);
        chk("reinit_flags", 64'({f.done_rise, f.init_rise}), 64'b01);
        check_cmd(0, "a_post_rst", 4'h3, 4'h2, 12'h0F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
